// File: rtl/vga_print_ctrl_if.sv
// Bus bundle between the control unit / text memory and vga_print_ctrl.
//
// Request semantics: vgae and clr are one-cycle strobes. The block accepts one
// only while busy is low. A strobe seen while busy is high is dropped and sets
// the sticky ovf flag. The control unit stalls its PC while busy is high.
// Text-memory writes carry no back-pressure. Each cycle with vram_we high
// writes vram_data at vram_addr. When vram_we is low, addr and data are
// don't-care, but they are always driven.
// dbg_state mirrors the internal FSM state for observation.
interface vga_print_ctrl_if;
  logic        vgae;
  logic [7:0]  data;
  logic        clr;
  logic        busy;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        ovf;
  logic [2:0]  dbg_state;

  modport master (
    output vgae, data, clr,
    input  busy, vram_we, vram_addr, vram_data, ovf, dbg_state
  );

  modport slave (
    input  vgae, data, clr,
    output busy, vram_we, vram_addr, vram_data, ovf, dbg_state
  );
endinterface

// File: rtl/vga_print_ctrl.sv
// vga_print_ctrl: prints an 8-bit register value as two hex digits and a space
// into an 80x30 text memory at a self-advancing cursor.
// Optional macro VGA_PRINT_CLEAR_EN adds a clear-screen function. It writes
// 0x20 to every cell, homes the cursor and clears ovf.
// Without the macro, clr is ignored entirely.
module vga_print_ctrl (
  input logic             clock,
  input logic             reset,
  vga_print_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    SEP  = 3'd3
`ifdef VGA_PRINT_CLEAR_EN
    , CLR = 3'd4
`endif
  } state_t;

`ifdef VGA_PRINT_CLEAR_EN
  localparam logic [11:0] LAST_CELL = 12'd2399;
  logic [11:0] clr_cnt;
`else
  logic unused_clr;
  assign unused_clr = bus.clr;
`endif

  state_t      state;
  logic [4:0]  row;
  logic [6:0]  col;
  logic [3:0]  lo_q;
  logic [4:0]  row_nx;
  logic [6:0]  col_nx;
  logic [11:0] cur_addr;
  logic        req_drop;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h37 + {4'd0, n};
  endfunction

  assign bus.dbg_state = state;

  // Cursor address and the next cursor position after one write; wraps without scrolling
  always_comb begin
    cur_addr = ({7'd0, row} * 12'd80) + {5'd0, col};
    row_nx   = row;
    col_nx   = col + 7'd1;
    if (col == 7'd79) begin
      col_nx = 7'd0;
      row_nx = (row == 5'd29) ? 5'd0 : row + 5'd1;
    end
  end

  // A request is dropped when it arrives while busy, or when vgae collides with an accepted clr
  always_comb begin
`ifdef VGA_PRINT_CLEAR_EN
    req_drop = (state != IDLE) ? (bus.vgae | bus.clr) : (bus.vgae & bus.clr);
`else
    req_drop = (state != IDLE) & bus.vgae;
`endif
  end

  // Print/clear FSM with registered outputs; each state's write is set up on entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      row           <= 5'd0;
      col           <= 7'd0;
      lo_q          <= 4'd0;
      bus.busy      <= 1'b0;
      bus.vram_we   <= 1'b0;
      bus.vram_addr <= 12'd0;
      bus.vram_data <= 8'h00;
      bus.ovf       <= 1'b0;
`ifdef VGA_PRINT_CLEAR_EN
      clr_cnt       <= 12'd0;
`endif
    end else begin
      if (req_drop) bus.ovf <= 1'b1;
      case (state)
        IDLE: begin
`ifdef VGA_PRINT_CLEAR_EN
          if (bus.clr) begin
            state         <= CLR;
            bus.busy      <= 1'b1;
            bus.vram_we   <= 1'b1;
            bus.vram_addr <= 12'd0;
            bus.vram_data <= 8'h20;
            clr_cnt       <= 12'd0;
          end else
`endif
          if (bus.vgae) begin
            state         <= HI;
            bus.busy      <= 1'b1;
            bus.vram_we   <= 1'b1;
            bus.vram_addr <= cur_addr;
            bus.vram_data <= hex_ascii(bus.data[7:4]);
            lo_q          <= bus.data[3:0];
            row           <= row_nx;
            col           <= col_nx;
          end
        end
        HI: begin
          state         <= LO;
          bus.vram_addr <= cur_addr;
          bus.vram_data <= hex_ascii(lo_q);
          row           <= row_nx;
          col           <= col_nx;
        end
        LO: begin
          state         <= SEP;
          bus.vram_addr <= cur_addr;
          bus.vram_data <= 8'h20;
          row           <= row_nx;
          col           <= col_nx;
        end
        SEP: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.vram_we <= 1'b0;
        end
`ifdef VGA_PRINT_CLEAR_EN
        CLR: begin
          if (clr_cnt == LAST_CELL) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.vram_we <= 1'b0;
            bus.ovf     <= 1'b0;
            row         <= 5'd0;
            col         <= 7'd0;
          end else begin
            clr_cnt       <= clr_cnt + 12'd1;
            bus.vram_addr <= clr_cnt + 12'd1;
          end
        end
`endif
        default: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.vram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_print_ctrl.md
VGA_PRINT_CTRL -- requirements
Module: vga_print_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clock` and `reset`.
REQ-002 Port `clock`: input, 1 bit; all state updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit; asynchronous, active-low.
REQ-004 Port `vgae`: input, 1 bit; print request strobe from the control unit, one cycle wide.
REQ-005 Port `data`: input, 8 bits; register value to print, sampled with `vgae`.
REQ-006 Port `clr`: input, 1 bit; clear-screen request strobe.
REQ-007 Port `busy`: output, 1 bit; registered; high while a print or clear is in progress, used to stall the PC.
REQ-008 Port `vram_we`: output, 1 bit; text-memory write enable.
REQ-009 Port `vram_addr`: output, 12 bits; cell address, computed as row*80+col.
REQ-010 Port `vram_data`: output, 8 bits; ASCII code to write.
REQ-011 Port `ovf`: output, 1 bit; sticky flag meaning a request was dropped.

Function
REQ-012 Screen geometry SHALL be 80 columns (col 0..79) by 30 rows (row 0..29), giving 2400 cells.
REQ-013 The FSM SHALL have the states IDLE, HI, LO, SEP and CLR; only IDLE accepts requests.
REQ-014 `vgae`=1 in IDLE at cycle N SHALL latch `data` and enter HI.
- HI, LO and SEP SHALL each last one cycle with `vram_we`=1, in cycles N+1, N+2 and N+3.
- The FSM SHALL return to IDLE at N+4.
REQ-015 HI SHALL write the hex digit for data[7:4]; LO SHALL write the hex digit for data[3:0]; SEP SHALL write 0x20.
REQ-016 Hex encoding SHALL map 0..9 to 0x30..0x39 and A..F to 0x41..0x46.
REQ-017 Each write SHALL use the current cursor address, and the cursor SHALL advance one cell after each write.
REQ-018 Cursor wrap:
- col 79 SHALL wrap to col 0 with row+1.
- row 29, col 79 SHALL wrap to row 0, col 0; there is no scrolling.
REQ-019 `busy` SHALL equal (state != IDLE), registered, so it is high from N+1 through N+3.
REQ-020 `vgae` or `clr` asserted while not in IDLE SHALL be ignored and SHALL set `ovf`=1.
REQ-021 When `vgae` and `clr` are asserted together in IDLE, `clr` SHALL win, `vgae` SHALL be dropped, and `ovf` SHALL be set.
REQ-022 `ovf` SHALL stay at 1 until reset, or until a completed clear when clear is compiled in.
REQ-023 When `vram_we`=0, `vram_addr` and `vram_data` SHALL be don't-care for the consumer but driven (no X).

Reset
REQ-024 While `reset`=0, the block SHALL immediately force:
- state IDLE
- cursor row 0, col 0
- `busy`=0, `vram_we`=0, `vram_data`=0x00, `ovf`=0
REQ-025 Reset asserted mid-print or mid-clear SHALL abort the operation with no further writes, and no partial state SHALL survive.

Configuration
REQ-026 Macro VGA_PRINT_CLEAR_EN SHALL control the clear function as follows.
- Defined: `clr` in IDLE enters CLR, which writes 0x20 to addresses 0..2399, one per cycle (2400 cycles, `vram_we`=1, `busy`=1). On completion the cursor is set to (0,0), `ovf` is cleared and the FSM returns to IDLE.
- Undefined: `clr` SHALL be ignored entirely. The CLR state and the clear counter are absent. REQ-021 reduces to `vgae` being served normally.

Verification
REQ-027 After reset, `vgae` with `data`=0x3C -> writes (addr 0, 0x33), (addr 1, 0x43), (addr 2, 0x20) in 3 consecutive cycles; `busy` high for 3 cycles; cursor then at col 3.
REQ-028 Cursor at row 0, col 78, `data`=0xFF -> writes (78, 0x46), (79, 0x46), (80, 0x20); cursor then at row 1, col 1.
REQ-029 Cursor at row 29, col 79, `data`=0x00 -> writes (2399, 0x30), (0, 0x30), (1, 0x20).
REQ-030 Second `vgae` in cycle N+2 -> still exactly 3 writes; `ovf`=1 and remains 1 afterwards.
REQ-031 With VGA_PRINT_CLEAR_EN defined, `clr` pulse -> 2400 writes of 0x20 at addresses 0..2399, `busy` high for 2400 cycles, cursor (0,0), `ovf`=0. With the macro undefined, the same pulse -> no writes and `busy` stays 0.
REQ-032 `reset`=0 asserted during LO -> `vram_we` drops without waiting for a clock edge; after release, `vgae` with 0xA5 -> writes (0, 0x41), (1, 0x35), (2, 0x20).
